// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int WORD_BYTES = 4;

  // Byte address to word index; upper bits wrap modulo depth (depth is a power of two).
  function automatic int unsigned addr_to_index(input logic [31:0] addr, input int unsigned depth);
    return (addr / WORD_BYTES) % depth;
  endfunction

endpackage

// File: rtl/dmem_wait_counter.sv
// Wait-state counter: load on request accept, count down in BUSY, flag zero.
module dmem_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - 4'd1;
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data RAM behind a fixed-latency stall/ready handshake for the MEM stage.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        stall,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  state_t          state, state_nx;
  logic            req;
  logic            latch, access, cnt_dec, cnt_zero;
  logic            r_rd, r_wr;
  logic [31:0]     r_addr, r_wdata;
  logic [AW-1:0]   idx;
  logic            illegal;
  logic [31:0]     mem [DEPTH];

  assign req     = memread | memwrite;
  assign stall   = req && (state != DONE);
  assign idx     = AW'(addr_to_index(r_addr, DEPTH));
  assign illegal = (r_addr[1:0] != 2'b00) || (r_rd && r_wr);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req)      state_nx = BUSY;
      BUSY:    if (cnt_zero) state_nx = DONE;
      DONE:                  state_nx = IDLE;
      default:               state_nx = IDLE;
    endcase
  end

  always_comb begin
    latch   = (state == IDLE) && req;
    cnt_dec = (state == BUSY) && !cnt_zero;
    access  = (state == BUSY) && cnt_zero;
  end

  dmem_wait_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (latch),
    .dec      (cnt_dec),
    .load_val (4'(WAIT_CYCLES)),
    .zero     (cnt_zero)
  );

  // Inputs are only trusted at the IDLE accept; everything after works off the latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (latch) begin
      r_rd    <= memread;
      r_wr    <= memwrite;
      r_addr  <= address;
      r_wdata <= writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (access && r_wr && !illegal) begin
      mem[idx] <= r_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
    end else if (access) begin
      readdata <= (r_rd && !illegal) ? mem[idx] : 32'h0;
      ready    <= 1'b1;
      err      <= illegal;
    end else if (state == DONE) begin
      ready    <= 1'b0;
      err      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed cases plus randomized traffic vs a word-array model.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int W     = 2;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memread = 1'b0, memwrite = 1'b0;
  logic [31:0] address = '0, writedata = '0;
  logic [31:0] readdata;
  logic        ready, stall, err;

  int          cyc = 0;
  int          n_cmp = 0, n_bad = 0;
  exp_t        q[$];
  logic [31:0] mm [DEPTH];

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .address(address), .writedata(writedata), .readdata(readdata),
    .ready(ready), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && ready) begin
        if (q.size() == 0) begin
          check("spurious_ready", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("readdata", readdata, e.data);
          check("err", {31'd0, err}, {31'd0, e.err});
          check("ready_cycle", cyc, e.cyc);
        end
      end else if (!reset && err) begin
        check("err_without_ready", 32'd1, 32'd0);
      end
    end
  end

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
  endfunction

  // Issue one request at a negedge (after gap idle cycles), hold it until IDLE returns.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input int gap);
    exp_t e;
    int   i;
    bit   bad;
    if (gap > 0) begin
      memread = 0; memwrite = 0;
      repeat (gap) begin
        #1 check("stall_idle", {31'd0, stall}, 32'd0);
        @(negedge clk);
      end
    end
    memread = rd; memwrite = wr; address = a; writedata = wd;
    i   = (a / 4) % DEPTH;
    bad = (a % 4 != 0) || (rd && wr);
    e.err  = bad;
    e.data = (rd && !bad) ? mm[i] : 32'h0;
    e.cyc  = cyc + W + 2;
    if (wr && !bad) mm[i] = wd;
    q.push_back(e);
    for (int k = 0; k <= W + 2; k++) begin
      #1 check("stall", {31'd0, stall}, (k <= W + 1) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    int gap;
    logic rd, wr;
    logic [31:0] a, wd;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_readdata", readdata, 32'h0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    reset = 0;
    #1 check("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);

    do_req(1, 0, 32'h0,   32'h0,        0);
    do_req(0, 1, 32'h10,  32'hDEADBEEF, 0);
    do_req(1, 0, 32'h10,  32'h0,        0);
    do_req(0, 1, 32'h13,  32'h1234,     1);
    do_req(1, 0, 32'h10,  32'h0,        0);
    do_req(1, 1, 32'h10,  32'h5555,     2);
    do_req(1, 0, 32'h10,  32'h0,        0);
    do_req(0, 1, 32'h400, 32'hCAFEF00D, 0);
    do_req(1, 0, 32'h0,   32'h0,        0);

    // Store aborted by reset in BUSY; the next read must see cleared memory.
    memread = 0; memwrite = 1; address = 32'h20; writedata = 32'hA5A5A5A5;
    repeat (2) @(negedge clk);
    reset = 1; memwrite = 0;
    @(negedge clk);
    reset = 0;
    model_clear();
    do_req(1, 0, 32'h20,  32'h0,        0);
    do_req(1, 0, 32'h400, 32'h0,        0);

    for (int n = 0; n < 200; n++) begin
      a  = {$urandom_range(3, 0) == 0 ? $urandom() : 32'h0} & 32'hFFFF_FC00;
      a  = a | ($urandom_range(15, 0) << 2);
      if ($urandom_range(7, 0) == 0) a = a | $urandom_range(3, 1);
      wd = $urandom();
      case ($urandom_range(15, 0))
        0:       begin rd = 1; wr = 1; end
        1,2,3,4,5,6,7: begin rd = 0; wr = 1; end
        default: begin rd = 1; wr = 0; end
      endcase
      gap = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(3, 1);
      do_req(rd, wr, a, wd, gap);
    end

    memread = 0; memwrite = 0;
    repeat (W + 5) @(negedge clk);
    check("outstanding", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
